// File: rtl/fproc_arb_pkg.sv
// Shared types for the fproc arbiter: FSM state encoding, timeout fill data and index-width helper.
package fproc_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } arb_state_e;

  // Wide enough for any practical DATA_WIDTH; sliced down at the use site.
  localparam logic [255:0] FP_TIMEOUT_DATA = '1;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fproc_rr_pick.sv
// Combinational round-robin selector: first set request at or after the pointer, wrapping at N_CORES-1.
module fproc_rr_pick
  import fproc_arb_pkg::*;
#(
  parameter int unsigned N_CORES = 4,
  parameter int unsigned PTR_W   = idx_w(N_CORES)
) (
  input  logic [N_CORES-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [PTR_W-1:0]   grant_o,
  output logic               any_o
);

  logic [PTR_W:0] cand;

  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < N_CORES; i++) begin
      cand = {1'b0, ptr_i} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(N_CORES)) cand = cand - (PTR_W+1)'(N_CORES);
      if (!any_o && req_i[cand[PTR_W-1:0]]) begin
        any_o   = 1'b1;
        grant_o = cand[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fproc_arbiter.sv
// Round-robin arbiter sharing one fproc request/response channel among N_CORES cores.
// Optional watchdog enabled by defining FPROC_ARB_TIMEOUT_EN (adds timeout_err port).
module fproc_arbiter
  import fproc_arb_pkg::*;
#(
  parameter int unsigned N_CORES        = 4,
  parameter int unsigned ID_WIDTH       = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_CORES-1:0]          core_req,
  input  logic [N_CORES*ID_WIDTH-1:0] core_id,
  output logic [N_CORES-1:0]          core_valid,
  output logic [DATA_WIDTH-1:0]       core_data,
  output logic                        fp_req,
  output logic [ID_WIDTH-1:0]         fp_id,
  input  logic                        fp_ack,
  input  logic                        fp_valid,
  input  logic [DATA_WIDTH-1:0]       fp_data,
  output logic                        busy,
`ifdef FPROC_ARB_TIMEOUT_EN
  output logic                        timeout_err,
`endif
  output logic                        stray_resp
);

  localparam int unsigned PTR_W = idx_w(N_CORES);

  arb_state_e            state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-1:0]      grant_q, grant_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  stray_q, stray_d;
  logic [PTR_W-1:0]      pick;
  logic                  pick_any;
  logic [ID_WIDTH-1:0]   sel_id;
  logic                  timeout_hit;

  fproc_rr_pick #(
    .N_CORES (N_CORES),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req_i   (core_req),
    .ptr_i   (ptr_q),
    .grant_o (pick),
    .any_o   (pick_any)
  );

  always_comb begin
    sel_id = '0;
    for (int unsigned k = 0; k < N_CORES; k++) begin
      if (pick == PTR_W'(k)) sel_id = core_id[k*ID_WIDTH +: ID_WIDTH];
    end
  end

`ifdef FPROC_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tout_q, tout_d;

  assign timeout_hit = (state_q == ST_ISSUE || state_q == ST_WAIT) &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && !fp_valid;

  always_comb begin
    cnt_d  = cnt_q;
    tout_d = tout_q;
    if (state_q == ST_IDLE) cnt_d = '0;
    else if (state_q == ST_ISSUE || state_q == ST_WAIT) cnt_d = cnt_q + 1'b1;
    if (timeout_hit) tout_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tout_q <= tout_d;
    end
  end

  assign timeout_err = tout_q;
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    id_d    = id_q;
    data_d  = data_q;
    stray_d = stray_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fp_valid) stray_d = 1'b1;
        if (pick_any) begin
          grant_d = pick;
          id_d    = sel_id;
          state_d = ST_ISSUE;
        end
      end
      // fp_valid without fp_ack is treated as an implicit ack; a result always beats the watchdog.
      ST_ISSUE, ST_WAIT: begin
        if (fp_valid) begin
          data_d  = fp_data;
          state_d = ST_RESPOND;
        end else if (timeout_hit) begin
`ifdef FPROC_ARB_TIMEOUT_EN
          data_d  = FP_TIMEOUT_DATA[DATA_WIDTH-1:0];
`endif
          state_d = ST_RESPOND;
        end else if (state_q == ST_ISSUE && fp_ack) begin
          state_d = ST_WAIT;
        end
      end
      ST_RESPOND: begin
        if (fp_valid) stray_d = 1'b1;
        ptr_d   = (grant_q == PTR_W'(N_CORES - 1)) ? '0 : grant_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      id_q    <= '0;
      data_q  <= '0;
      stray_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      data_q  <= data_d;
      stray_q <= stray_d;
    end
  end

  always_comb begin
    core_valid = '0;
    if (state_q == ST_RESPOND) core_valid[grant_q] = 1'b1;
  end

  assign fp_req     = (state_q == ST_ISSUE);
  assign fp_id      = id_q;
  assign core_data  = data_q;
  assign busy       = (state_q != ST_IDLE);
  assign stray_resp = stray_q;

endmodule

// File: tb/tb_fproc_arbiter.sv
// Scoreboard bench for fproc_arbiter: a core model, a directed downstream driver and a response monitor.
module tb_fproc_arbiter;

  localparam int N  = 4;
  localparam int IW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  core_req;
  logic [N*IW-1:0] core_id;
  logic [N-1:0]  core_valid;
  logic [DW-1:0] core_data;
  logic          fp_req;
  logic [IW-1:0] fp_id;
  logic          fp_ack;
  logic          fp_valid;
  logic [DW-1:0] fp_data;
  logic          busy;
  logic          stray_resp;
`ifdef FPROC_ARB_TIMEOUT_EN
  logic          timeout_err;
`endif

  int errors = 0;
  int checks = 0;

  int issued [N];
  int done   [N];
  logic [N-1:0] gap;

  int            sb_core [$];
  logic [DW-1:0] sb_data [$];

  always #5 clk = ~clk;

  fproc_arbiter #(
    .N_CORES        (N),
    .ID_WIDTH       (IW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .core_req    (core_req),
    .core_id     (core_id),
    .core_valid  (core_valid),
    .core_data   (core_data),
    .fp_req      (fp_req),
    .fp_id       (fp_id),
    .fp_ack      (fp_ack),
    .fp_valid    (fp_valid),
    .fp_data     (fp_data),
    .busy        (busy),
`ifdef FPROC_ARB_TIMEOUT_EN
    .timeout_err (timeout_err),
`endif
    .stray_resp  (stray_resp)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Core model: a request stays up while transactions are outstanding, dropping for the cycle after each response.
  always_comb begin
    for (int k = 0; k < N; k++) core_req[k] = (issued[k] > done[k]) && !gap[k];
  end

  initial begin
    gap = '0;
    for (int k = 0; k < N; k++) done[k] = 0;
    forever begin
      @(negedge clk);
      gap = core_valid;
      for (int k = 0; k < N; k++) if (core_valid[k]) done[k] = done[k] + 1;
    end
  end

  // Monitor: every response strobe must match the oldest expected response.
  initial begin
    int c;
    logic [DW-1:0] d;
    logic [N-1:0] exp_v;
    forever begin
      @(negedge clk);
      if (core_valid !== '0) begin
        if (sb_core.size() == 0) begin
          check("unexpected_core_valid", 32'(core_valid), 32'h0);
        end else begin
          c = sb_core.pop_front();
          d = sb_data.pop_front();
          exp_v = '0;
          exp_v[c] = 1'b1;
          check("core_valid", 32'(core_valid), 32'(exp_v));
          check("core_data", core_data, d);
        end
      end
    end
  end

  task automatic set_id(input int k, input logic [IW-1:0] v);
    core_id[k*IW +: IW] = v;
  endtask

  // mode 0: ack, valid 3 cycles later; mode 1: ack+valid together; mode 2: valid only (implicit ack)
  task automatic serve(input int core, input logic [IW-1:0] id, input int mode, input int dly,
                       input logic [DW-1:0] d);
    int n;
    n = 0;
    while (fp_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("fp_req_seen", 32'(fp_req), 32'h1);
    check("fp_id", 32'(fp_id), 32'(id));
    sb_core.push_back(core);
    sb_data.push_back(d);
    repeat (dly) begin
      @(negedge clk);
      check("fp_req_hold", 32'(fp_req), 32'h1);
      check("fp_id_hold", 32'(fp_id), 32'(id));
    end
    case (mode)
      0: begin
        fp_ack = 1'b1;
        @(negedge clk);
        fp_ack = 1'b0;
        check("wait_fp_req_low", 32'(fp_req), 32'h0);
        repeat (2) @(negedge clk);
        fp_valid = 1'b1;
        fp_data  = d;
        @(negedge clk);
        fp_valid = 1'b0;
      end
      1: begin
        fp_ack   = 1'b1;
        fp_valid = 1'b1;
        fp_data  = d;
        @(negedge clk);
        fp_ack   = 1'b0;
        fp_valid = 1'b0;
      end
      default: begin
        fp_valid = 1'b1;
        fp_data  = d;
        @(negedge clk);
        fp_valid = 1'b0;
      end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset    = 1'b1;
    fp_ack   = 1'b0;
    fp_valid = 1'b0;
    fp_data  = '0;
    core_id  = '0;
    for (int k = 0; k < N; k++) issued[k] = 0;
    repeat (2) @(negedge clk);
    check("rst_core_valid", 32'(core_valid), 32'h0);
    check("rst_core_data", core_data, 32'h0);
    check("rst_fp_req", 32'(fp_req), 32'h0);
    check("rst_fp_id", 32'(fp_id), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_stray", 32'(stray_resp), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Round-robin fairness from pointer 0: grants 0,1,2,3,0.
    for (int k = 0; k < N; k++) set_id(k, 8'(8'h10 + k));
    issued[0] = 2; issued[1] = 1; issued[2] = 1; issued[3] = 1;
    serve(0, 8'h10, 1, 0, 32'hA0A0_0000);
    serve(1, 8'h11, 0, 1, 32'hA1A1_1111);
    serve(2, 8'h12, 2, 0, 32'hA2A2_2222);
    serve(3, 8'h13, 1, 1, 32'hA3A3_3333);
    serve(0, 8'h10, 1, 0, 32'hA0A0_4444);
    repeat (2) @(negedge clk);

    // Single request, core 2, 1-cycle request latency.
    set_id(2, 8'h15);
    issued[2] = issued[2] + 1;
    @(negedge clk);
    check("single_latency_fp_req", 32'(fp_req), 32'h1);
    check("single_busy", 32'(busy), 32'h1);
    serve(2, 8'h15, 0, 1, 32'hDEAD_BEEF);
    repeat (2) @(negedge clk);

    // Same-cycle ack and valid: IDLE -> ISSUE -> RESPOND.
    set_id(1, 8'h2A);
    issued[1] = issued[1] + 1;
    @(negedge clk);
    check("same_fp_req", 32'(fp_req), 32'h1);
    serve(1, 8'h2A, 1, 0, 32'h0000_0001);
    check("same_respond_valid", 32'(core_valid), 32'h2);
    check("same_respond_data", core_data, 32'h1);
    @(negedge clk);
    check("same_back_idle", 32'(busy), 32'h0);
    @(negedge clk);

    // Implicit ack; core_id changes after the grant are ignored.
    set_id(0, 8'h33);
    issued[0] = issued[0] + 1;
    @(negedge clk);
    set_id(0, 8'h99);
    serve(0, 8'h33, 2, 2, 32'h1234_5678);
    repeat (2) @(negedge clk);

    // Reset while in WAIT (pointer is 1 beforehand).
    set_id(3, 8'h77);
    issued[3] = issued[3] + 1;
    @(negedge clk);
    check("rstw_fp_req", 32'(fp_req), 32'h1);
    fp_ack = 1'b1;
    @(negedge clk);
    fp_ack = 1'b0;
    check("rstw_in_wait_busy", 32'(busy), 32'h1);
    check("rstw_in_wait_fp_req", 32'(fp_req), 32'h0);
    reset = 1'b1;
    issued[3] = issued[3] - 1;
    @(negedge clk);
    check("rstw_busy", 32'(busy), 32'h0);
    check("rstw_fp_req", 32'(fp_req), 32'h0);
    check("rstw_fp_id", 32'(fp_id), 32'h0);
    check("rstw_core_data", core_data, 32'h0);
    check("rstw_core_valid", 32'(core_valid), 32'h0);
    check("rstw_stray", 32'(stray_resp), 32'h0);
    fp_valid = 1'b1;
    fp_data  = 32'hBAD0_0000;
    @(negedge clk);
    fp_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    check("valid_during_reset_no_stray", 32'(stray_resp), 32'h0);

    // Stray response in IDLE: sticky, no response strobe.
    fp_valid = 1'b1;
    fp_data  = 32'hBAD0_0001;
    @(negedge clk);
    fp_valid = 1'b0;
    check("stray_set", 32'(stray_resp), 32'h1);
    repeat (3) @(negedge clk);
    check("stray_held", 32'(stray_resp), 32'h1);
    check("stray_idle", 32'(busy), 32'h0);

    // Pointer back at 0 after reset: cores 0 and 2 together, core 0 first.
    set_id(0, 8'h40);
    set_id(2, 8'h42);
    issued[0] = issued[0] + 1;
    issued[2] = issued[2] + 1;
    serve(0, 8'h40, 0, 1, 32'h0000_0055);
    serve(2, 8'h42, 1, 0, 32'h0000_0066);
    @(negedge clk);
    check("stray_still_held", 32'(stray_resp), 32'h1);

`ifdef FPROC_ARB_TIMEOUT_EN
    // Watchdog: ack but never a result.
    set_id(1, 8'h5C);
    issued[1] = issued[1] + 1;
    @(negedge clk);
    check("tout_fp_id", 32'(fp_id), 32'h5C);
    sb_core.push_back(1);
    sb_data.push_back(32'hFFFF_FFFF);
    fp_ack = 1'b1;
    @(negedge clk);
    fp_ack = 1'b0;
    n = 0;
    while (core_valid === '0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("tout_response_seen", 32'(core_valid), 32'h2);
    @(negedge clk);
    check("tout_err", 32'(timeout_err), 32'h1);
`endif

    n = 0;
    while (sb_core.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 32'(sb_core.size()), 32'h0);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
